sdiv32: RTL

Signed 32-bit sequential divider: accepts a dividend and divisor on a `start` pulse, computes quotient and remainder with one restoring shift-subtract step per clock, and reports completion on `done`. It is the inverse-arithmetic companion to the serial signed multiplier and shares the same start/done handshake, so an arithmetic unit can drive both blocks identically. Latency is fixed and data-independent, including divide-by-zero and overflow.

---
 rtl/sdiv_pkg.sv | 14 +
 rtl/sdiv_step.sv | 31 +++
 rtl/sdiv32.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sdiv_pkg.sv
// Shared definitions for the sequential signed divider family:
// FSM state encoding and the default operand width.
package sdiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sdiv_step.sv
// One restoring shift-subtract step on magnitudes: shift {rem,quo} left,
// subtract the divisor magnitude and keep the difference if it is non-negative.
module sdiv_step
    import sdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   dvm_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, dvm_i};
        // The top bit of trial is its sign: clear means the subtraction fits.
        if (!trial[WIDTH+1]) begin
            rem_o = trial[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sdiv32.sv
// Signed sequential divider: magnitudes are divided one bit per clock, then
// signs are applied in a single FIX cycle. Latency is a fixed 33 cycles.
module sdiv32
    import sdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dd,
    input  logic [WIDTH-1:0] dv,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvm_q, dvm_d;
    logic [WIDTH-1:0] dd_q, dd_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0] qout_q, qout_d, rout_q, rout_d;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    sdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvm_i (dvm_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvm_d   = dvm_q;
        dd_d    = dd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        qout_d  = qout_q;
        rout_d  = rout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    // Negating 0x80000000 wraps to itself, which is the correct magnitude.
                    quo_d   = dd[WIDTH-1] ? -dd : dd;
                    dvm_d   = dv[WIDTH-1] ? -{dv[WIDTH-1], dv} : {1'b0, dv};
                    dd_d    = dd;
                    qneg_d  = dd[WIDTH-1] ^ dv[WIDTH-1];
                    rneg_d  = dd[WIDTH-1];
                    dz_d    = (dv == '0);
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (dz_q) begin
                    qout_d = '1;
                    rout_d = dd_q;
                end else begin
                    qout_d = qneg_q ? -quo_q : quo_q;
                    rout_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvm_q   <= '0;
            dd_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvm_q   <= dvm_d;
            dd_q    <= dd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    assign q    = qout_q;
    assign r    = rout_q;
    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

endmodule
